// File: rtl/rollback_handler_pkg.sv
// rollback_handler_pkg: shared widths, types and FSM encodings for the rollback path
package rollback_handler_pkg;
  localparam int THREAD_NUMB = 4;
  localparam int ADDR_W = 32;
  localparam int SB_W = 64;
  typedef logic [ADDR_W-1:0] address_t;
  typedef logic [$clog2(THREAD_NUMB)-1:0] thread_id_t;
  typedef logic [SB_W-1:0] scoreboard_t;
  typedef logic [THREAD_NUMB-1:0] thread_mask_t;
  typedef logic [0:0] rb_state_t;
  localparam rb_state_t RB_IDLE = 1'b0;
  localparam rb_state_t RB_SQUASH = 1'b1;
endpackage

// File: rtl/rollback_handler_if.sv
// rollback_handler_if: branch/writeback rollback inputs and fetch/scheduler outputs
interface rollback_handler_if
  import rollback_handler_pkg::*;
#(parameter int THREAD_NUMB = rollback_handler_pkg::THREAD_NUMB);
  logic bc_rollback_enable;
  logic bc_rollback_valid;
  address_t bc_rollback_pc;
  thread_id_t bc_rollback_thread_id;
  scoreboard_t bc_scoreboard;
  logic wb_rollback_enable;
  address_t wb_rollback_pc;
  thread_id_t wb_rollback_thread_id;
  logic [THREAD_NUMB-1:0] rb_rollback_valid;
  address_t rb_rollback_pc [THREAD_NUMB];
  logic [THREAD_NUMB-1:0] rb_squash_mask;
  logic rb_release_valid;
  thread_id_t rb_release_thread_id;
  scoreboard_t rb_release_scoreboard;
  modport master (
    output bc_rollback_enable, bc_rollback_valid, bc_rollback_pc, bc_rollback_thread_id, bc_scoreboard,
    output wb_rollback_enable, wb_rollback_pc, wb_rollback_thread_id,
    input rb_rollback_valid, rb_rollback_pc, rb_squash_mask,
    input rb_release_valid, rb_release_thread_id, rb_release_scoreboard
  );
  modport slave (
    input bc_rollback_enable, bc_rollback_valid, bc_rollback_pc, bc_rollback_thread_id, bc_scoreboard,
    input wb_rollback_enable, wb_rollback_pc, wb_rollback_thread_id,
    output rb_rollback_valid, rb_rollback_pc, rb_squash_mask,
    output rb_release_valid, rb_release_thread_id, rb_release_scoreboard
  );
endinterface

// File: rtl/rollback_handler_thread_fsm.sv
// rollback_thread_fsm: one thread's redirect pulse, redirect PC and squash window
module rollback_thread_fsm
  import rollback_handler_pkg::*;
#(parameter int SQUASH_CYCLES = 3) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_accept,
  input  address_t i_pc,
  output logic     o_valid,
  output address_t o_pc,
  output logic     o_squash
);
  localparam int CW = $clog2(SQUASH_CYCLES + 1);
  rb_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic r_valid;
  address_t r_pc;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RB_IDLE;
      r_cnt <= '0;
      r_valid <= 1'b0;
      r_pc <= '0;
    end else begin
      r_valid <= i_accept;
      if (i_accept) begin
        r_pc <= i_pc;
        r_state <= RB_SQUASH;
        r_cnt <= CW'(SQUASH_CYCLES - 1);
      end else if (r_state == RB_SQUASH) begin
        if (r_cnt == '0) r_state <= RB_IDLE;
        else r_cnt <= r_cnt - 1'b1;
      end
    end
  end
  assign o_valid = r_valid;
  assign o_pc = r_pc;
  assign o_squash = (r_state == RB_SQUASH);
endmodule

// File: rtl/rollback_handler.sv
// rollback_handler: arbitrates branch/trap rollbacks per thread and releases branch scoreboard bits
module rollback_handler
  import rollback_handler_pkg::*;
#(
  parameter int THREAD_NUMB = rollback_handler_pkg::THREAD_NUMB,
  parameter int SQUASH_CYCLES = 3
) (
  input logic clk,
  input logic reset,
  rollback_handler_if.slave bus
);
  logic [THREAD_NUMB-1:0] w_accept, w_valid, w_squash;
  address_t w_pc_in [THREAD_NUMB];
  address_t w_pc [THREAD_NUMB];
  logic r_rel_valid;
  thread_id_t r_rel_tid;
  scoreboard_t r_rel_sb;
  for (genvar t = 0; t < THREAD_NUMB; t++) begin : g_thr
    // writeback is the older instruction, so it wins; a branch seen while squashed is wrong-path
    logic w_wb_hit, w_bc_hit;
    assign w_wb_hit = bus.wb_rollback_enable && bus.wb_rollback_thread_id == thread_id_t'(t);
    assign w_bc_hit = bus.bc_rollback_enable && bus.bc_rollback_thread_id == thread_id_t'(t) && !w_squash[t];
    assign w_accept[t] = w_wb_hit || w_bc_hit;
    assign w_pc_in[t] = w_wb_hit ? bus.wb_rollback_pc : bus.bc_rollback_pc;
    rollback_thread_fsm #(.SQUASH_CYCLES(SQUASH_CYCLES)) u_fsm (
      .clk(clk),
      .reset(reset),
      .i_accept(w_accept[t]),
      .i_pc(w_pc_in[t]),
      .o_valid(w_valid[t]),
      .o_pc(w_pc[t]),
      .o_squash(w_squash[t])
    );
    assign bus.rb_rollback_pc[t] = w_pc[t];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rel_valid <= 1'b0;
      r_rel_tid <= '0;
      r_rel_sb <= '0;
    end else begin
      r_rel_valid <= bus.bc_rollback_enable || bus.bc_rollback_valid;
      r_rel_tid <= bus.bc_rollback_thread_id;
      r_rel_sb <= bus.bc_scoreboard;
    end
  end
  assign bus.rb_rollback_valid = w_valid;
  assign bus.rb_squash_mask = w_squash;
  assign bus.rb_release_valid = r_rel_valid;
  assign bus.rb_release_thread_id = r_rel_tid;
  assign bus.rb_release_scoreboard = r_rel_sb;
endmodule

// File: tb/tb_rollback_handler.sv
// tb_rollback_handler: directed rollback scenarios with hand-computed expectations
module tb_rollback_handler;
  import rollback_handler_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  rollback_handler_if bus ();
  rollback_handler #(.SQUASH_CYCLES(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    bus.bc_rollback_enable = 0;
    bus.bc_rollback_valid = 0;
    bus.bc_rollback_pc = '0;
    bus.bc_rollback_thread_id = '0;
    bus.bc_scoreboard = '0;
    bus.wb_rollback_enable = 0;
    bus.wb_rollback_pc = '0;
    bus.wb_rollback_thread_id = '0;
  endtask
  task automatic branch(input thread_id_t t, input address_t pc, input scoreboard_t sb);
    bus.bc_rollback_enable = 1;
    bus.bc_rollback_thread_id = t;
    bus.bc_rollback_pc = pc;
    bus.bc_scoreboard = sb;
  endtask
  task automatic trap(input thread_id_t t, input address_t pc);
    bus.wb_rollback_enable = 1;
    bus.wb_rollback_thread_id = t;
    bus.wb_rollback_pc = pc;
  endtask
  initial begin
    idle();
    step();
    step();
    reset = 0;
    check("rst_valid", 64'(bus.rb_rollback_valid), 0);
    check("rst_mask", 64'(bus.rb_squash_mask), 0);
    check("rst_rel", 64'(bus.rb_release_valid), 0);
    check("rst_pc0", 64'(bus.rb_rollback_pc[0]), 0);
    // thread 0 taken branch
    branch(0, 32'h400, 64'hA5);
    step();
    idle();
    check("t0_valid", 64'(bus.rb_rollback_valid), 1);
    check("t0_pc", 64'(bus.rb_rollback_pc[0]), 32'h400);
    check("t0_mask1", 64'(bus.rb_squash_mask), 1);
    check("t0_rel_v", 64'(bus.rb_release_valid), 1);
    check("t0_rel_tid", 64'(bus.rb_release_thread_id), 0);
    check("t0_rel_sb", bus.rb_release_scoreboard, 64'hA5);
    step();
    check("t0_pulse_end", 64'(bus.rb_rollback_valid), 0);
    check("t0_mask2", 64'(bus.rb_squash_mask), 1);
    check("t0_rel_end", 64'(bus.rb_release_valid), 0);
    step();
    check("t0_mask3", 64'(bus.rb_squash_mask), 1);
    step();
    check("t0_mask_off", 64'(bus.rb_squash_mask), 0);
    // thread 1: second branch inside its own window is ignored
    branch(1, 32'h200, 64'h11);
    step();
    check("t1_valid", 64'(bus.rb_rollback_valid), 2);
    check("t1_pc", 64'(bus.rb_rollback_pc[1]), 32'h200);
    branch(1, 32'h300, 64'h22);
    step();
    idle();
    check("t1_ign_valid", 64'(bus.rb_rollback_valid), 0);
    check("t1_ign_pc", 64'(bus.rb_rollback_pc[1]), 32'h200);
    check("t1_ign_rel_v", 64'(bus.rb_release_valid), 1);
    check("t1_ign_rel_tid", 64'(bus.rb_release_thread_id), 1);
    check("t1_ign_rel_sb", bus.rb_release_scoreboard, 64'h22);
    check("t1_ign_mask", 64'(bus.rb_squash_mask), 2);
    step();
    check("t1_mask3", 64'(bus.rb_squash_mask), 2);
    step();
    check("t1_mask_off", 64'(bus.rb_squash_mask), 0);
    // thread 2 branch and trap together: trap wins
    branch(2, 32'h100, 64'h5);
    trap(2, 32'h80);
    step();
    idle();
    check("t2_valid", 64'(bus.rb_rollback_valid), 4);
    check("t2_pc", 64'(bus.rb_rollback_pc[2]), 32'h80);
    step();
    check("t2_single_pulse", 64'(bus.rb_rollback_valid), 0);
    step();
    step();
    check("t2_mask_off", 64'(bus.rb_squash_mask), 0);
    // thread 0 branch and thread 3 trap together
    branch(0, 32'h500, 64'h7);
    trap(3, 32'h600);
    step();
    idle();
    check("t03_valid", 64'(bus.rb_rollback_valid), 9);
    check("t03_pc0", 64'(bus.rb_rollback_pc[0]), 32'h500);
    check("t03_pc3", 64'(bus.rb_rollback_pc[3]), 32'h600);
    check("t03_mask", 64'(bus.rb_squash_mask), 9);
    step();
    step();
    step();
    check("t03_mask_off", 64'(bus.rb_squash_mask), 0);
    // trap in the second cycle of thread 1's window restarts it
    branch(1, 32'h700, 64'h0);
    step();
    idle();
    step();
    trap(1, 32'h740);
    step();
    idle();
    check("ext_valid", 64'(bus.rb_rollback_valid), 2);
    check("ext_pc", 64'(bus.rb_rollback_pc[1]), 32'h740);
    step();
    check("ext_mask_a", 64'(bus.rb_squash_mask), 2);
    step();
    check("ext_mask_b", 64'(bus.rb_squash_mask), 2);
    step();
    check("ext_mask_off", 64'(bus.rb_squash_mask), 0);
    // not-taken branch-pipe instruction still releases its bits
    bus.bc_rollback_valid = 1;
    bus.bc_rollback_thread_id = 3;
    bus.bc_scoreboard = 64'h33;
    step();
    idle();
    check("nt_valid", 64'(bus.rb_rollback_valid), 0);
    check("nt_rel_v", 64'(bus.rb_release_valid), 1);
    check("nt_rel_tid", 64'(bus.rb_release_thread_id), 3);
    check("nt_rel_sb", bus.rb_release_scoreboard, 64'h33);
    // reset one cycle after a rollback
    branch(2, 32'h900, 64'h9);
    step();
    check("pre_rst_valid", 64'(bus.rb_rollback_valid), 4);
    reset = 1;
    branch(3, 32'hABC, 64'hC);
    step();
    reset = 0;
    idle();
    check("mid_rst_valid", 64'(bus.rb_rollback_valid), 0);
    check("mid_rst_mask", 64'(bus.rb_squash_mask), 0);
    check("mid_rst_pc2", 64'(bus.rb_rollback_pc[2]), 0);
    check("mid_rst_pc3", 64'(bus.rb_rollback_pc[3]), 0);
    check("mid_rst_rel", 64'(bus.rb_release_valid), 0);
    branch(2, 32'h910, 64'h1);
    step();
    idle();
    check("post_rst_valid", 64'(bus.rb_rollback_valid), 4);
    check("post_rst_pc", 64'(bus.rb_rollback_pc[2]), 32'h910);
    check("post_rst_mask", 64'(bus.rb_squash_mask), 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
